fifo_drain_arbiter: RTL

//  Round-robin drain scheduler for n_src fifo_buffer instances. Pops words from

---
 rtl/fifo_drain_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/fifo_drain_arbiter.sv
// fifo_drain_arbiter
//   Round-robin drain scheduler for n_src first-word-fall-through FIFOs.
//   Each grant pops up to burst_max words from one source, then gives the
//   next source its turn. Popped words go through one registered
//   valid/ready output stage and are tagged with their source index.
//
// Ports
//   clk, reset      clock; synchronous active-high reset
//   enable          1 = scheduling allowed, 0 = no new pops
//   src_nonempty    per-source FIFO nonempty flags
//   src_data        per-source FIFO heads, source i at [i*data_width +: data_width]
//   src_next        per-source pop strobe (combinational, one-hot or zero)
//   out_data        registered output word
//   out_src         source index of out_data
//   out_valid       out_data/out_src hold a word
//   out_ready       consumer takes the word when out_valid && out_ready
//   busy            a grant is active or a word is still held
module fifo_drain_arbiter #(
    parameter int data_width = 8,
    parameter int n_src      = 4,
    parameter int burst_max  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [n_src-1:0]              src_nonempty,
    input  logic [n_src*data_width-1:0]   src_data,
    output logic [n_src-1:0]              src_next,
    output logic [data_width-1:0]         out_data,
    output logic [$clog2(n_src)-1:0]      out_src,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy
);

    localparam int idx_w = $clog2(n_src);
    // burst_cnt only ever holds 0..burst_max-1; the last pop of a burst
    // releases the grant and clears it.
    localparam int cnt_w = (burst_max > 1) ? $clog2(burst_max) : 1;
    localparam logic [idx_w-1:0] last_idx = idx_w'(n_src - 1);
    localparam logic [cnt_w-1:0] cnt_last = cnt_w'(burst_max - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                 state, state_nx;
    logic [idx_w-1:0]       grant, grant_nx;
    logic [idx_w-1:0]       rr_ptr, rr_ptr_nx;
    logic [cnt_w-1:0]       burst_cnt, burst_cnt_nx;
    logic                   load;
    logic [idx_w-1:0]       pick;
    logic                   pick_ok;
    logic [data_width-1:0]  grant_data;
    int                     j;

    assign grant_data = src_data[int'(grant)*data_width +: data_width];

    // First nonempty source at or after rr_ptr, wrapping n_src-1 -> 0.
    // The wrap is done on an int so non-power-of-2 n_src never indexes
    // past the last source.
    always_comb begin
        pick    = rr_ptr;
        pick_ok = 1'b0;
        j       = 0;
        for (int k = 0; k < n_src; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= n_src) j = j - n_src;
            if (!pick_ok && src_nonempty[j[idx_w-1:0]]) begin
                pick    = j[idx_w-1:0];
                pick_ok = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx     = state;
        grant_nx     = grant;
        rr_ptr_nx    = rr_ptr;
        burst_cnt_nx = burst_cnt;
        load         = 1'b0;
        src_next     = '0;
        case (state)
            IDLE: begin
                // Arbitration only; the first pop of a grant is next cycle.
                if (enable && pick_ok) begin
                    grant_nx = pick;
                    state_nx = ACTIVE;
                end
            end
            ACTIVE: begin
                load = enable && src_nonempty[grant] && (!out_valid || out_ready);
                if (load) begin
                    src_next[grant] = 1'b1;
                    burst_cnt_nx    = burst_cnt + 1'b1;
                end
                // Backpressure alone never releases: the grant is held as
                // long as the source still has data and enable is high.
                if ((load && burst_cnt == cnt_last) || !src_nonempty[grant] || !enable) begin
                    state_nx     = IDLE;
                    burst_cnt_nx = '0;
                    rr_ptr_nx    = (grant == last_idx) ? '0 : grant + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        // No pop may escape while reset is held (the FIFOs see src_next
        // even though our own registers are being cleared).
        if (reset) begin
            load     = 1'b0;
            src_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nx;
            grant     <= grant_nx;
            rr_ptr    <= rr_ptr_nx;
            burst_cnt <= burst_cnt_nx;
        end
    end

    // Output stage: a load replaces the held word in the same cycle it is
    // consumed, so back-to-back pops leave no bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_src   <= grant;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign busy = (state == ACTIVE) || out_valid;

endmodule
